vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 800x600@60 counter.
//  Produces pixel/line counters, sync, blanking, data-enable, line/frame strobes and a frame counter.
//  Sits between the pixel-clock source and every draw/fill engine (e.g. line drawer, frame-buffer reader).
//  Adds to the fixed version: clock enable, sync polarity, synchronous reset and strobes.
// PARAMETERS
//  CNT_W     11   width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE  800  visible pixels per line
//  H_FP      40   horizontal front porch, pixels
//  H_SYNC    128  hsync pulse width, pixels
//  H_BP      88   horizontal back porch, pixels (H_TOTAL = sum = 1056)
//  V_ACTIVE  600  visible lines per frame
//  V_FP      1    vertical front porch, lines
//  V_SYNC    4    vsync pulse width, lines
//  V_BP      23   vertical back porch, lines (V_TOTAL = sum = 628)
//  HS_POL    1    1 = hsync active-high, 0 = active-low
//  VS_POL    1    1 = vsync active-high, 0 = active-low
//  FRAME_W   8    width of frame_cnt
// PORTS
//  pclk       in   1        pixel clock; all logic on rising edge
//  rst        in   1        synchronous active-high reset
//  ce         in   1        pixel advance enable; low = counters and outputs hold
//  hcount     out  CNT_W    pixel index in line, 0..H_TOTAL-1
//  vcount     out  CNT_W    line index in frame, 0..V_TOTAL-1
//  hsync      out  1        horizontal sync, polarity per HS_POL
//  vsync      out  1        vertical sync, polarity per VS_POL
//  hblnk      out  1        1 when hcount >= H_ACTIVE
//  vblnk      out  1        1 when vcount >= V_ACTIVE
//  de         out  1        ~hblnk & ~vblnk (active video)
//  eol        out  1        1 when hcount == H_TOTAL-1
//  sof        out  1        1 when hcount == 0 and vcount == 0 (first active pixel)
//  frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W
// BEHAVIOUR
//  - Reset: rst=1 at an edge forces hcount=0, vcount=0, frame_cnt=0; rst has priority over ce.
//    While rst is high: de=0, eol=0, sof=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL.
//    Reset mid-line/mid-frame restarts at (0,0) on the next edge, with no partial-line completion.
//  - First cycle after rst falls: hcount=0, vcount=0, sof=1, de=1.
//  - ce=1: hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
//    vcount wraps H_TOTAL-1 & V_TOTAL-1 -> (0,0) with frame_cnt+1 (modulo 2^FRAME_W).
//  - ce=0: all counters hold; decoded outputs stay consistent with the held counters.
//    eol/sof therefore stay high while stalled on their position.
//  - hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
//  - vsync active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for entire lines.
//  - Latency: decoded outputs are combinational from the counter registers (0 cycles), unless the macro is set.
//  - Counter compares use full CNT_W width; no count ever exceeds TOTAL-1.
//  - Elaboration check: CNT_W too narrow for H_TOTAL/V_TOTAL -> $error.
// CONFIGURATION
//  VGA_TIMING_REG_OUT_EN defined:
//   - All outputs (counts, syncs, blanks, de, eol, sof, frame_cnt) come from an output register stage.
//   - They are delayed exactly 1 pclk, mutually aligned and glitch-free; the register advances only when ce=1.
//   - Output reset values are as listed under Reset, applied on the same edge.
//  VGA_TIMING_REG_OUT_EN undefined: combinational decode, 0-cycle latency.
// TESTING
//  1 Defaults, ce=1, run 1056*628 cycles after rst -> one hsync pulse per line at hcount 840..967;
//    vsync high for lines 601..604; frame_cnt=1 at wrap.
//  2 de count per frame -> exactly 480000 (800*600); eol pulses per frame -> 628; sof pulses per frame -> 1.
//  3 HS_POL=0, VS_POL=0 -> hsync low only at 840..967, vsync low only at lines 601..604, high during reset.
//  4 ce toggled 1/0 every cycle -> sequence identical to test 1 at half rate; no count skipped or repeated.
//  5 rst pulsed 1 cycle at hcount=500, vcount=300 -> next cycle (0,0), sof=1, frame_cnt=0.
//  6 Small config H=8/2/2/2, V=4/1/1/1, FRAME_W=2, run 5 frames -> frame_cnt 0,1,2,3,0.
//    Rerun with VGA_TIMING_REG_OUT_EN -> same trace shifted 1 cycle.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: counters, syncs, blanking, strobes and frame count.
// master drives (timing generator), slave observes (draw/fill engines).
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 8
);
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic               de;
  logic               eol;
  logic               sof;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, eol, sof, frame_cnt
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, de, eol, sof, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with clock enable, sync polarity and frame counter.
// Define VGA_TIMING_REG_OUT_EN to register every output (1 pclk latency); otherwise 0-cycle decode.
module vga_timing_gen #(
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int FRAME_W  = 8
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  vga_timing_gen_if.master tim_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CNT_W + 1;

  // One extra bit so sync-end bounds equal to TOTAL still compare correctly.
  localparam logic [CW1-1:0] H_ACT_C  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] V_ACT_C  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] HS_BEG_C = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] HS_END_C = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] VS_BEG_C = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] VS_END_C = CW1'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_cnt_w_chk
    $error("vga_timing_gen: CNT_W=%0d too narrow for H_TOTAL=%0d V_TOTAL=%0d",
           CNT_W, H_TOTAL, V_TOTAL);
  end

  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    if (ce_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d  = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
    end
  end

  logic [CW1-1:0] h_ext, v_ext;
  logic hblnk_c, vblnk_c, de_c, eol_c, sof_c, hsync_c, vsync_c;

  assign h_ext = {1'b0, hcnt_q};
  assign v_ext = {1'b0, vcnt_q};

  // Decoded flags are forced idle while reset is asserted, independent of counter state.
  always_comb begin
    hblnk_c = 1'b0;
    vblnk_c = 1'b0;
    de_c    = 1'b0;
    eol_c   = 1'b0;
    sof_c   = 1'b0;
    hsync_c = ~HS_POL;
    vsync_c = ~VS_POL;
    if (!rst_i) begin
      hblnk_c = (h_ext >= H_ACT_C);
      vblnk_c = (v_ext >= V_ACT_C);
      de_c    = ~hblnk_c & ~vblnk_c;
      eol_c   = (hcnt_q == H_LAST);
      sof_c   = (hcnt_q == '0) && (vcnt_q == '0);
      if (h_ext >= HS_BEG_C && h_ext < HS_END_C) hsync_c = HS_POL;
      if (v_ext >= VS_BEG_C && v_ext < VS_END_C) vsync_c = VS_POL;
    end
  end

`ifdef VGA_TIMING_REG_OUT_EN
  logic [CNT_W-1:0]   hcount_q, vcount_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic hsync_q, vsync_q, hblnk_q, vblnk_q, de_q, eol_q, sof_q;

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      de_q        <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
    end else if (ce_i) begin
      hcount_q    <= hcnt_q;
      vcount_q    <= vcnt_q;
      frame_cnt_q <= frame_q;
      hsync_q     <= hsync_c;
      vsync_q     <= vsync_c;
      hblnk_q     <= hblnk_c;
      vblnk_q     <= vblnk_c;
      de_q        <= de_c;
      eol_q       <= eol_c;
      sof_q       <= sof_c;
    end
  end

  assign tim_o.hcount    = hcount_q;
  assign tim_o.vcount    = vcount_q;
  assign tim_o.frame_cnt = frame_cnt_q;
  assign tim_o.hsync     = hsync_q;
  assign tim_o.vsync     = vsync_q;
  assign tim_o.hblnk     = hblnk_q;
  assign tim_o.vblnk     = vblnk_q;
  assign tim_o.de        = de_q;
  assign tim_o.eol       = eol_q;
  assign tim_o.sof       = sof_q;
`else
  assign tim_o.hcount    = hcnt_q;
  assign tim_o.vcount    = vcnt_q;
  assign tim_o.frame_cnt = frame_q;
  assign tim_o.hsync     = hsync_c;
  assign tim_o.vsync     = vsync_c;
  assign tim_o.hblnk     = hblnk_c;
  assign tim_o.vblnk     = vblnk_c;
  assign tim_o.de        = de_c;
  assign tim_o.eol       = eol_c;
  assign tim_o.sof       = sof_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations against a position-based raster model,
// plus literal pins on the model and on per-frame pulse counts.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
    int fw;
  } cfg_t;

  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
    logic hs, vs, hb, vb, de, eol, sof;
    logic [7:0] fc;
  } obs_t;

`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  cfg_t cfg_a = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 8};
  cfg_t cfg_b = '{16, 4, 6, 4, 10, 2, 3, 2, 1'b1, 1'b1, 3};
  cfg_t cfg_c = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  longint pa = 0, pb = 0, pc = 0;
  obs_t ra, rb, rc;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(11), .FRAME_W(8)) if_a ();
  vga_timing_gen_if #(.CNT_W(5),  .FRAME_W(3)) if_b ();
  vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2)) if_c ();

  vga_timing_gen dut_a (.pclk_i(clk), .rst_i(rst), .ce_i(ce), .tim_o(if_a));

  vga_timing_gen #(
    .CNT_W(5), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(3)
  ) dut_b (.pclk_i(clk), .rst_i(rst), .ce_i(ce), .tim_o(if_b));

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(2)
  ) dut_c (.pclk_i(clk), .rst_i(rst), .ce_i(ce), .tim_o(if_c));

  // p = pixels advanced since the last reset; everything follows from raster arithmetic.
  function automatic obs_t model(cfg_t c, longint p, bit r);
    obs_t m;
    longint ht, vt, h, v;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    h  = p % ht;
    v  = (p / ht) % vt;
    m.hc  = 16'(h);
    m.vc  = 16'(v);
    m.fc  = 8'((p / (ht * vt)) % (longint'(1) << c.fw));
    m.hb  = 1'b0;
    m.vb  = 1'b0;
    m.de  = 1'b0;
    m.eol = 1'b0;
    m.sof = 1'b0;
    m.hs  = ~c.hp;
    m.vs  = ~c.vp;
    if (!r) begin
      m.hb  = (h >= c.ha);
      m.vb  = (v >= c.va);
      m.de  = !m.hb && !m.vb;
      m.eol = (h == ht - 1);
      m.sof = (h == 0) && (v == 0);
      if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) m.hs = c.hp;
      if (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) m.vs = c.vp;
    end
    return m;
  endfunction

  function automatic obs_t obs_of(input logic [15:0] hc, input logic [15:0] vc,
                                  input logic hs, input logic vs, input logic hb,
                                  input logic vb, input logic de, input logic eol,
                                  input logic sof, input logic [7:0] fc);
    obs_t o;
    o.hc = hc; o.vc = vc; o.hs = hs; o.vs = vs; o.hb = hb;
    o.vb = vb; o.de = de; o.eol = eol; o.sof = sof; o.fc = fc;
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b de=%b eol=%b sof=%b fc=%0d expected hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b de=%b eol=%b sof=%b fc=%0d",
               name, $time, act.hc, act.vc, act.hs, act.vs, act.hb, act.vb, act.de, act.eol,
               act.sof, act.fc, exp.hc, exp.vc, exp.hs, exp.vs, exp.hb, exp.vb, exp.de,
               exp.eol, exp.sof, exp.fc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
`ifdef VGA_TIMING_REG_OUT_EN
      ra = model(cfg_a, 0, 1'b1);
      rb = model(cfg_b, 0, 1'b1);
      rc = model(cfg_c, 0, 1'b1);
`endif
      pa = 0; pb = 0; pc = 0;
      started = 1'b1;
    end else if (ce) begin
`ifdef VGA_TIMING_REG_OUT_EN
      ra = model(cfg_a, pa, 1'b0);
      rb = model(cfg_b, pb, 1'b0);
      rc = model(cfg_c, pc, 1'b0);
`endif
      pa++; pb++; pc++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      obs_t ea, eb, ec;
`ifdef VGA_TIMING_REG_OUT_EN
      ea = ra; eb = rb; ec = rc;
`else
      ea = model(cfg_a, pa, rst);
      eb = model(cfg_b, pb, rst);
      ec = model(cfg_c, pc, rst);
`endif
      chk_obs("trace_a", obs_of(16'(if_a.hcount), 16'(if_a.vcount), if_a.hsync, if_a.vsync,
              if_a.hblnk, if_a.vblnk, if_a.de, if_a.eol, if_a.sof, 8'(if_a.frame_cnt)), ea);
      chk_obs("trace_b", obs_of(16'(if_b.hcount), 16'(if_b.vcount), if_b.hsync, if_b.vsync,
              if_b.hblnk, if_b.vblnk, if_b.de, if_b.eol, if_b.sof, 8'(if_b.frame_cnt)), eb);
      chk_obs("trace_c", obs_of(16'(if_c.hcount), 16'(if_c.vcount), if_c.hsync, if_c.vsync,
              if_c.hblnk, if_c.vblnk, if_c.de, if_c.eol, if_c.sof, 8'(if_c.frame_cnt)), ec);
    end
  end

  initial begin
    obs_t o;
    int de_b = 0, eol_b = 0, sof_b = 0, hs_b = 0, vs_b = 0;
    int hs_c_low = 0, vs_c_low = 0;
    int hs_a = 0, de_a = 0, first_hs_a = -1;
    int fc_exp[5] = '{0, 1, 2, 3, 0};

    // Literal pins on the model for the default 800x600 raster and the tiny config.
    o = model(cfg_a, 839, 1'b0);          chk("pin_hs_839", o.hs, 0);
    o = model(cfg_a, 840, 1'b0);          chk("pin_hs_840", o.hs, 1);
    o = model(cfg_a, 967, 1'b0);          chk("pin_hs_967", o.hs, 1);
    o = model(cfg_a, 968, 1'b0);          chk("pin_hs_968", o.hs, 0);
    o = model(cfg_a, 1056*601 - 1, 1'b0); chk("pin_vs_600", o.vs, 0);
    o = model(cfg_a, 1056*601, 1'b0);     chk("pin_vs_601", o.vs, 1);
    o = model(cfg_a, 1056*605 - 1, 1'b0); chk("pin_vs_604", o.vs, 1);
    o = model(cfg_a, 1056*605, 1'b0);     chk("pin_vs_605", o.vs, 0);
    o = model(cfg_a, 1056*628, 1'b0);     chk("pin_wrap_fc", o.fc, 1);
    chk("pin_wrap_pos", {o.hc, o.vc}, 0);
    o = model(cfg_a, 799, 1'b0);          chk("pin_de_799", o.de, 1);
    o = model(cfg_a, 800, 1'b0);          chk("pin_de_800", o.de, 0);
    o = model(cfg_c, 98*3, 1'b0);         chk("pin_c_fc3", o.fc, 3);
    o = model(cfg_c, 98*4, 1'b0);         chk("pin_c_fc_wrap", o.fc, 0);
    o = model(cfg_c, 5, 1'b1);            chk("pin_c_rst_hs", o.hs, 1);

    rst = 1'b1; ce = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hcount_a", if_a.hcount, 0);
    chk("rst_de_b", if_b.de, 0);
    chk("rst_hsync_c", if_c.hsync, 1);
    chk("rst_vsync_c", if_c.vsync, 1);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b1;

    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (k == LAT) begin
        chk("first_hcount_a", if_a.hcount, 0);
        chk("first_vcount_a", if_a.vcount, 0);
        chk("first_sof_a", if_a.sof, 1);
        chk("first_de_a", if_a.de, 1);
      end
      if (k >= LAT && k < LAT + 510) begin
        de_b += int'(if_b.de); eol_b += int'(if_b.eol); sof_b += int'(if_b.sof);
        hs_b += int'(if_b.hsync); vs_b += int'(if_b.vsync);
      end
      if (k >= LAT && k < LAT + 98) begin
        hs_c_low += int'(!if_c.hsync); vs_c_low += int'(!if_c.vsync);
      end
      for (int i = 0; i < 5; i++) begin
        if (k == LAT + i*98) begin
          chk("c_frame_cnt_seq", if_c.frame_cnt, fc_exp[i]);
          chk("c_sof_seq", if_c.sof, 1);
        end
      end
      if (k >= LAT && k < LAT + 1056) begin
        hs_a += int'(if_a.hsync); de_a += int'(if_a.de);
        if (if_a.hsync && first_hs_a < 0) first_hs_a = k - LAT;
      end
      @(posedge clk); #1;
    end
    chk("b_de_per_frame", de_b, 160);
    chk("b_eol_per_frame", eol_b, 17);
    chk("b_sof_per_frame", sof_b, 1);
    chk("b_hsync_per_frame", hs_b, 102);
    chk("b_vsync_per_frame", vs_b, 90);
    chk("c_hsync_low_per_frame", hs_c_low, 14);
    chk("c_vsync_low_per_frame", vs_c_low, 14);
    chk("a_hsync_per_line", hs_a, 128);
    chk("a_hsync_start", first_hs_a, 840);
    chk("a_de_line0", de_a, 800);

    for (int i = 0; i < 4000; i++) begin
      ce = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 1000; i++) begin
      ce = (i % 2 == 0);
      @(posedge clk); #1;
    end

    // Single-cycle reset pulse somewhere mid-frame.
    ce = 1'b1;
    repeat (37) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pulse_hcount_b", if_b.hcount, 0);
    chk("pulse_vcount_b", if_b.vcount, 0);
    chk("pulse_sof_b", if_b.sof, 1);
    chk("pulse_frame_b", if_b.frame_cnt, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; ce = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
